// File: rtl/nano6502_pkg.sv
// rtl/nano6502_pkg.sv - shared IO constants and PS/2 receive state type
package nano6502_pkg;

    localparam logic [15:0] KBD_BANK = 16'h0006;

    localparam logic [1:0] KBD_DATA   = 2'd0;
    localparam logic [1:0] KBD_STATUS = 2'd1;
    localparam logic [1:0] KBD_CTRL   = 2'd2;
    localparam logic [1:0] KBD_COUNT  = 2'd3;

    localparam int ST_NOT_EMPTY  = 0;
    localparam int ST_OVERFLOW   = 1;
    localparam int ST_PARITY_ERR = 2;
    localparam int ST_FRAME_ERR  = 3;
    localparam int ST_IRQ_EN     = 4;

    typedef enum logic [2:0] {
        PS2_IDLE   = 3'd0,
        PS2_START  = 3'd1,
        PS2_DATA   = 3'd2,
        PS2_PARITY = 3'd3,
        PS2_STOP   = 3'd4
    } ps2_state_t;

    // PS/2 uses odd parity over the 8 data bits plus the parity bit
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 pin synchroniser, clock glitch filter and frame receiver
module ps2_rx_frame
    import nano6502_pkg::*;
#(
    parameter int CLK_HZ     = 27000000,
    parameter int TIMEOUT_US = 200
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       parity_err,
    output logic       frame_err
);

    localparam longint unsigned TO_CYC = (longint'(CLK_HZ) * longint'(TIMEOUT_US)) / 64'd1000000;
    localparam int TW = $clog2(TO_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

    logic          clk_meta, clk_sync, dat_meta, dat_sync;
    logic [2:0]    clk_hist;
    logic          clk_filt;
    logic          fall;
    ps2_state_t    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          start_bit, par_bit;
    logic [TW-1:0] to_cnt;

    // the filtered clock only changes after three agreeing samples
    assign fall    = clk_filt && (clk_hist == 3'b000);
    assign rx_byte = shift;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            clk_meta   <= 1'b1;
            clk_sync   <= 1'b1;
            dat_meta   <= 1'b1;
            dat_sync   <= 1'b1;
            clk_hist   <= 3'b111;
            clk_filt   <= 1'b1;
            state      <= PS2_IDLE;
            bit_cnt    <= 3'd0;
            shift      <= 8'h00;
            start_bit  <= 1'b0;
            par_bit    <= 1'b0;
            to_cnt     <= '0;
            byte_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            clk_meta   <= ps2_clk_i;
            clk_sync   <= clk_meta;
            dat_meta   <= ps2_dat_i;
            dat_sync   <= dat_meta;
            clk_hist   <= {clk_hist[1:0], clk_sync};
            if (clk_hist == 3'b111) clk_filt <= 1'b1;
            else if (clk_hist == 3'b000) clk_filt <= 1'b0;

            byte_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;

            if (state == PS2_IDLE || fall) to_cnt <= '0;
            else                           to_cnt <= to_cnt + 1'b1;

            if (state != PS2_IDLE && !fall && to_cnt == TO_LAST) begin
                frame_err <= 1'b1;
                state     <= PS2_IDLE;
            end else begin
                unique case (state)
                    PS2_IDLE: if (fall) begin
                        start_bit <= dat_sync;
                        state     <= PS2_START;
                    end
                    PS2_START: begin
                        bit_cnt <= 3'd0;
                        if (start_bit) begin
                            frame_err <= 1'b1;
                            state     <= PS2_IDLE;
                        end else begin
                            state <= PS2_DATA;
                        end
                    end
                    PS2_DATA: if (fall) begin
                        shift   <= {dat_sync, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PS2_PARITY;
                    end
                    PS2_PARITY: if (fall) begin
                        par_bit <= dat_sync;
                        state   <= PS2_STOP;
                    end
                    PS2_STOP: if (fall) begin
                        state <= PS2_IDLE;
                        if (!dat_sync)                           frame_err  <= 1'b1;
                        else if (!odd_parity_ok(shift, par_bit)) parity_err <= 1'b1;
                        else                                     byte_valid <= 1'b1;
                    end
                    default: state <= PS2_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_kbd.sv
// rtl/ps2_kbd.sv - PS/2 keyboard receiver with scan-code FIFO behind a 4-register CPU window
module ps2_kbd
    import nano6502_pkg::*;
#(
    parameter int CLK_HZ     = 27000000,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT_US = 200
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       R_W_n,
    input  logic [1:0] reg_addr_i,
    input  logic [1:0] reg_addr_r_i,
    input  logic [7:0] data_i,
    input  logic       kbd_cs,
    output logic [7:0] data_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       irq_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic          rx_valid, rx_par_err, rx_frm_err;
    logic [7:0]    rx_byte;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          overflow, parity_err, frame_err, irq_en;
    logic          wr_en, flush, empty, full, do_pop, do_push, ovf_set;
    logic [2:0]    flag_clr;
    logic [7:0]    rd_mux;
    logic          unused_data;

    ps2_rx_frame #(
        .CLK_HZ     (CLK_HZ),
        .TIMEOUT_US (TIMEOUT_US)
    ) u_rx (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_dat_i  (ps2_dat_i),
        .byte_valid (rx_valid),
        .rx_byte    (rx_byte),
        .parity_err (rx_par_err),
        .frame_err  (rx_frm_err)
    );

    assign unused_data = ^data_i[7:4];
    assign wr_en    = kbd_cs && !R_W_n;
    assign flush    = wr_en && (reg_addr_i == KBD_CTRL) && data_i[1];
    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign do_pop   = kbd_cs && R_W_n && (reg_addr_i == KBD_DATA) && !empty && !flush;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts the byte
    assign do_push  = rx_valid && !flush && (!full || do_pop);
    assign ovf_set  = rx_valid && !flush && full && !do_pop;
    assign flag_clr = (wr_en && reg_addr_i == KBD_STATUS) ? data_i[3:1] : 3'b000;

    always_ff @(posedge clk_i) begin
        if (do_push) fifo_mem[wr_ptr] <= rx_byte;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            irq_en     <= 1'b0;
            irq_o      <= 1'b0;
            data_o     <= 8'h00;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(do_push) - CW'(do_pop);
            end
            overflow   <= ovf_set    || (overflow   && !flag_clr[0]);
            parity_err <= rx_par_err || (parity_err && !flag_clr[1]);
            frame_err  <= rx_frm_err || (frame_err  && !flag_clr[2]);
            if (wr_en && reg_addr_i == KBD_CTRL) irq_en <= data_i[0];
            irq_o  <= irq_en && !empty;
            data_o <= rd_mux;
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        case (reg_addr_r_i)
            KBD_DATA:   rd_mux = empty ? 8'h00 : fifo_mem[rd_ptr];
            KBD_STATUS: begin
                rd_mux[ST_NOT_EMPTY]  = !empty;
                rd_mux[ST_OVERFLOW]   = overflow;
                rd_mux[ST_PARITY_ERR] = parity_err;
                rd_mux[ST_FRAME_ERR]  = frame_err;
                rd_mux[ST_IRQ_EN]     = irq_en;
            end
            KBD_CTRL:   rd_mux = {7'b0, irq_en};
            default:    rd_mux = 8'(count);
        endcase
    end

endmodule

// File: tb/tb_ps2_kbd.sv
// tb/tb_ps2_kbd.sv - self-checking bench for ps2_kbd against a queue-based reference model
module tb_ps2_kbd;

    localparam int CLK_HZ = 1000000;
    localparam int DEPTH  = 16;
    localparam int TO_US  = 200;
    localparam int H      = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       R_W_n = 1'b1;
    logic [1:0] reg_addr = 2'd0;
    logic [1:0] reg_addr_r = 2'd0;
    logic [7:0] wdata = 8'h00;
    logic       kbd_cs = 1'b0;
    logic [7:0] data_o;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       irq_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mq[$];
    bit m_ovf, m_par, m_frm, m_irq_en;

    ps2_kbd #(.CLK_HZ(CLK_HZ), .FIFO_DEPTH(DEPTH), .TIMEOUT_US(TO_US)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .R_W_n        (R_W_n),
        .reg_addr_i   (reg_addr),
        .reg_addr_r_i (reg_addr_r),
        .data_i       (wdata),
        .kbd_cs       (kbd_cs),
        .data_o       (data_o),
        .ps2_clk_i    (ps2_clk),
        .ps2_dat_i    (ps2_dat),
        .irq_o        (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 0; m_par = 0; m_frm = 0; m_irq_en = 0;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        tick(H);
        ps2_clk = 1'b0;
        tick(H);
        ps2_clk = 1'b1;
    endtask

    task automatic send_partial(input logic [7:0] d, input int nbits);
        ps2_bit(1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(d[i]);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic p;
        p = ~(^d) ^ bad_par;
        send_partial(d, 8);
        ps2_bit(p);
        ps2_bit(!bad_stop);
        ps2_dat = 1'b1;
        tick(H);
        if (bad_stop)               m_frm = 1;
        else if (bad_par)           m_par = 1;
        else if (mq.size() < DEPTH) mq.push_back(d);
        else                        m_ovf = 1;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [7:0] v);
        reg_addr_r = a;
        tick(1);
        v = data_o;
        kbd_cs = 1'b1; R_W_n = 1'b1; reg_addr = a;
        tick(1);
        kbd_cs = 1'b0;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        kbd_cs = 1'b1; R_W_n = 1'b0; reg_addr = a; wdata = d;
        tick(1);
        kbd_cs = 1'b0; R_W_n = 1'b1;
        if (a == 2'd1) begin
            if (d[1]) m_ovf = 0;
            if (d[2]) m_par = 0;
            if (d[3]) m_frm = 0;
        end else if (a == 2'd2) begin
            m_irq_en = d[0];
            if (d[1]) mq.delete();
        end
    endtask

    task automatic read_data(input string tag);
        logic [7:0] v, exp;
        cpu_read(2'd0, v);
        exp = (mq.size() != 0) ? mq.pop_front() : 8'h00;
        check(tag, v, exp);
    endtask

    task automatic check_regs(input string tag);
        logic [7:0] v, exp_st;
        cpu_read(2'd3, v);
        check({tag, "_count"}, v, mq.size());
        exp_st = {3'b000, m_irq_en, m_frm, m_par, m_ovf, mq.size() != 0};
        cpu_read(2'd1, v);
        check({tag, "_status"}, v, exp_st);
    endtask

    initial begin
        logic [7:0] v;
        model_reset();
        tick(5);
        check("rst_data_o", data_o, 8'h00);
        check("rst_irq", irq_o, 1'b0);
        rst_n = 1'b1;
        tick(2 * H);
        check_regs("rst");

        // basic good frame
        send_frame(8'h1C, 0, 0);
        check_regs("t1");
        read_data("t1_data");
        check_regs("t1_after");

        // parity error, then software clear
        send_frame(8'h5A, 1, 0);
        check_regs("t2");
        cpu_write(2'd1, 8'h04);
        check_regs("t2_clr");

        // overflow
        for (int i = 1; i <= 17; i++) send_frame(8'(i), 0, 0);
        check_regs("t3");
        for (int i = 0; i < 17; i++) read_data("t3_data");
        cpu_write(2'd1, 8'h02);
        check_regs("t3_clr");

        // timeout mid-frame
        send_partial(8'hA5, 4);
        ps2_dat = 1'b1;
        tick(250);
        m_frm = 1;
        check_regs("t4");
        cpu_write(2'd1, 8'h08);
        send_frame(8'hF0, 0, 0);
        read_data("t4_data");

        // irq and flush
        cpu_write(2'd2, 8'h01);
        send_frame(8'h29, 0, 0);
        tick(2);
        check("t5_irq_set", irq_o, 1'b1);
        read_data("t5_data");
        check("t5_irq_pop_edge", irq_o, 1'b1);
        tick(1);
        check("t5_irq_clear", irq_o, 1'b0);
        for (int i = 0; i < 3; i++) send_frame(8'h30 + 8'(i), 0, 0);
        check_regs("t5_queued");
        cpu_write(2'd2, 8'h03);
        check_regs("t5_flush");
        tick(1);
        check("t5_irq_flush", irq_o, 1'b0);

        // reset in the middle of a frame
        send_frame(8'h55, 0, 0);
        send_partial(8'h12, 5);
        reg_addr_r = 2'd3;
        tick(2);
        check("t6_pre_data", data_o, 8'h01);
        rst_n = 1'b0;
        #1;
        check("t6_rst_data", data_o, 8'h00);
        check("t6_rst_irq", irq_o, 1'b0);
        model_reset();
        tick(3);
        rst_n = 1'b1;
        ps2_dat = 1'b1;
        tick(2 * H);
        check_regs("t6_after_rst");
        send_frame(8'h76, 0, 0);
        read_data("t6_data");

        // randomized mix against the model
        cpu_write(2'd2, 8'h01);
        for (int it = 0; it < 40; it++) begin
            int unsigned op;
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                send_frame(8'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
            end else if (op <= 7) begin
                read_data("rnd_data");
            end else if (op == 8) begin
                check_regs("rnd");
            end else begin
                cpu_write(2'd1, 8'($urandom) & 8'h0E);
            end
            tick(2);
            check("rnd_irq", irq_o, m_irq_en && mq.size() != 0);
        end
        check_regs("rnd_end");
        while (mq.size() != 0) read_data("rnd_drain");
        check_regs("rnd_drained");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
